// File: rtl/alu_exec_pkg.sv
// Shared constants for the ALU execution unit: data width, ALU control codes, FSM states.
// ALU_EXEC_SLT_EN (when defined) enables the signed set-less-than code in alu_exec_comb.
package alu_exec_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_SLL = 3'b011;
    localparam logic [2:0] CTRL_SUB = 3'b110;
    localparam logic [2:0] CTRL_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_exec_comb.sv
// Single-cycle ALU datapath: add/sub/and/or (and slt under ALU_EXEC_SLT_EN) plus illegal-code decode.
module alu_exec_comb
    import alu_exec_pkg::*;
(
    input  logic [2:0]        alu_ctrl_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              illegal_o
);

`ifdef ALU_EXEC_SLT_EN
    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    assign a_s = op_a_i;
    assign b_s = op_b_i;
`endif

    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        case (alu_ctrl_i)
            CTRL_ADD: result_o = op_a_i + op_b_i;
            CTRL_SUB: result_o = op_a_i - op_b_i;
            CTRL_AND: result_o = op_a_i & op_b_i;
            CTRL_OR:  result_o = op_a_i | op_b_i;
            // Legal here; the actual shift amount is applied by the parent.
            CTRL_SLL: result_o = op_b_i;
`ifdef ALU_EXEC_SLT_EN
            CTRL_SLT: result_o = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
`endif
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: IDLE/SHIFT/DONE handshake FSM, iterative left shifter and output registers.
// Build option ALU_EXEC_SLT_EN (see alu_exec_comb) turns code 111 into signed set-less-than.
module alu_exec_unit
    import alu_exec_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         alu_ctrl,
    input  logic [DATA_W-1:0]  op_a,
    input  logic [DATA_W-1:0]  op_b,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  result,
    output logic               zero,
    output logic               illegal
);

    state_e              state_q, state_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                zero_q, zero_d;
    logic                ill_q, ill_d;
    logic [DATA_W-1:0]   comb_res;
    logic                comb_ill;
    logic [DATA_W-1:0]   single_res;
    logic [DATA_W-1:0]   sh_next;
    logic                accept;
    logic                long_sll;

    alu_exec_comb u_comb (
        .alu_ctrl_i (alu_ctrl),
        .op_a_i     (op_a),
        .op_b_i     (op_b),
        .result_o   (comb_res),
        .illegal_o  (comb_ill)
    );

    assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept     = in_valid && in_ready && !flush;
    assign long_sll   = (alu_ctrl == CTRL_SLL) && (shamt > SHAMT_W'(1));
    assign single_res = (alu_ctrl == CTRL_SLL) ? (op_b << shamt) : comb_res;
    assign sh_next    = sh_q << 1;

    // The first shift happens on the accept edge, so a shift by k shows out_valid k cycles after accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (state_q == ST_SHIFT) begin
            sh_d  = sh_next;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == SHAMT_W'(1)) begin
                state_d = ST_DONE;
                res_d   = sh_next;
                zero_d  = (sh_next == '0);
                ill_d   = 1'b0;
            end
        end else if (accept) begin
            if (long_sll) begin
                state_d = ST_SHIFT;
                sh_d    = op_b << 1;
                cnt_d   = shamt - 1'b1;
            end else begin
                state_d = ST_DONE;
                res_d   = single_res;
                zero_d  = (single_res == '0);
                ill_d   = comb_ill;
            end
        end else if ((state_q == ST_DONE) && out_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

    always_ff @(posedge clk) begin
        sh_q <= sh_d;
    end

    assign out_valid = (state_q == ST_DONE);
    assign result    = res_q;
    assign zero      = zero_q;
    assign illegal   = ill_q;

endmodule
